// File: rtl/cordic_req_arbiter.sv
// cordic_req_arbiter
// Round-robin front end that shares one iterative CORDIC engine between
// NUM_REQ requesters. One angle is latched per transaction, the engine is
// held enabled until it reports done, the result is returned to the granted
// requester, and the engine is only re-armed once its done has cleared.
//
// Build option: define CORDIC_ARB_TIMEOUT_EN to add a watchdog that aborts a
// stalled engine run with a quiet-NaN result and rsp_error set. Without it,
// RUN waits for done indefinitely and rsp_error is constant 0.

module cordic_req_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int REQ_IDX_WIDTH    = 2,
  parameter int FLOAT_DATA_WIDTH = 32,
  parameter int TIMEOUT_WIDTH    = 10,
  parameter int TIMEOUT_CYCLES   = 1000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*FLOAT_DATA_WIDTH-1:0]   req_angle,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [FLOAT_DATA_WIDTH-1:0]           rsp_result,
  output logic                                  rsp_error,
  output logic                                  busy,
  output logic                                  cordic_clk_en,
  output logic [FLOAT_DATA_WIDTH-1:0]           cordic_angle,
  input  logic                                  cordic_done,
  input  logic [FLOAT_DATA_WIDTH-1:0]           cordic_result
);

  // Parameter sanity checks, resolved at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("cordic_req_arbiter: NUM_REQ must be 2..8");
  end
  if (REQ_IDX_WIDTH != $clog2(NUM_REQ)) begin : g_bad_idx_width
    $error("cordic_req_arbiter: REQ_IDX_WIDTH must equal clog2(NUM_REQ)");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TIMEOUT_WIDTH)) begin : g_bad_timeout
    $error("cordic_req_arbiter: TIMEOUT_CYCLES must fit in TIMEOUT_WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    RUN     = 3'd2,
    RESP    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [REQ_IDX_WIDTH-1:0] idx);
    idx_onehot = NUM_REQ'(1) << idx;
  endfunction

  // Index of the requester after idx, wrapping at NUM_REQ (which need not be a power of two).
  function automatic logic [REQ_IDX_WIDTH-1:0] idx_next(input logic [REQ_IDX_WIDTH-1:0] idx);
    if (idx == REQ_IDX_WIDTH'(NUM_REQ - 1)) begin
      idx_next = '0;
    end else begin
      idx_next = idx + REQ_IDX_WIDTH'(1);
    end
  endfunction

  state_t                        state_r;
  logic [REQ_IDX_WIDTH-1:0]      rr_ptr_r;
  logic [REQ_IDX_WIDTH-1:0]      grant_idx_r;
  logic [FLOAT_DATA_WIDTH-1:0]   result_r;

  logic                          grant_found_s;
  logic [REQ_IDX_WIDTH-1:0]      grant_sel_s;
  logic [REQ_IDX_WIDTH-1:0]      cand_s;
  logic [FLOAT_DATA_WIDTH-1:0]   sel_angle_s;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam logic [FLOAT_DATA_WIDTH-1:0] QNAN         = FLOAT_DATA_WIDTH'(32'h7FC0_0000);
  localparam logic [TIMEOUT_WIDTH-1:0]    TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_WIDTH-1:0]      watchdog_r;
  logic                          timed_out_r;
  logic                          rsp_error_r;
  assign rsp_error = rsp_error_r;
`else
  assign rsp_error = 1'b0;
`endif

  // Round-robin pick: first asserted request scanning from rr_ptr upward, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_sel_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = REQ_IDX_WIDTH'((int'(rr_ptr_r) + k) % NUM_REQ);
      if (!grant_found_s && req_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_sel_s   = cand_s;
      end else begin
        grant_sel_s   = grant_sel_s;
      end
    end
  end

  // Angle slice belonging to the requester being picked.
  always_comb begin
    sel_angle_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_sel_s == REQ_IDX_WIDTH'(i)) begin
        sel_angle_s = req_angle[i*FLOAT_DATA_WIDTH +: FLOAT_DATA_WIDTH];
      end else begin
        sel_angle_s = sel_angle_s;
      end
    end
  end

  // Transaction FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      rr_ptr_r      <= '0;
      grant_idx_r   <= '0;
      result_r      <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
      busy          <= 1'b0;
      cordic_clk_en <= 1'b0;
      cordic_angle  <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      watchdog_r    <= '0;
      timed_out_r   <= 1'b0;
      rsp_error_r   <= 1'b0;
`endif
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      rsp_error_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (grant_found_s) begin
            req_ready    <= idx_onehot(grant_sel_s);
            cordic_angle <= sel_angle_s;
            grant_idx_r  <= grant_sel_s;
            busy         <= 1'b1;
            state_r      <= GRANT;
          end else begin
            busy         <= 1'b0;
            state_r      <= IDLE;
          end
        end
        GRANT: begin
          // A done level still visible here belongs to nothing we started; ignore it.
          cordic_clk_en <= 1'b1;
`ifdef CORDIC_ARB_TIMEOUT_EN
          watchdog_r    <= '0;
`endif
          state_r       <= RUN;
        end
        RUN: begin
          if (cordic_done) begin
            result_r    <= cordic_result;
`ifdef CORDIC_ARB_TIMEOUT_EN
            timed_out_r <= 1'b0;
`endif
            state_r     <= RESP;
          end
`ifdef CORDIC_ARB_TIMEOUT_EN
          else if (watchdog_r == TIMEOUT_LAST) begin
            result_r    <= QNAN;
            timed_out_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            watchdog_r  <= watchdog_r + TIMEOUT_WIDTH'(1);
            state_r     <= RUN;
          end
`else
          else begin
            state_r     <= RUN;
          end
`endif
        end
        RESP: begin
          rsp_valid     <= idx_onehot(grant_idx_r);
          rsp_result    <= result_r;
          rr_ptr_r      <= idx_next(grant_idx_r);
          cordic_clk_en <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
          rsp_error_r   <= timed_out_r;
          watchdog_r    <= '0;
`endif
          state_r       <= RELEASE;
        end
        RELEASE: begin
          // Engine must report not-done before it may be re-armed.
          if (!cordic_done) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
`ifdef CORDIC_ARB_TIMEOUT_EN
          else if (watchdog_r == TIMEOUT_LAST) begin
            busy       <= 1'b0;
            state_r    <= IDLE;
          end else begin
            watchdog_r <= watchdog_r + TIMEOUT_WIDTH'(1);
            state_r    <= RELEASE;
          end
`else
          else begin
            state_r <= RELEASE;
          end
`endif
        end
        default: begin
          cordic_clk_en <= 1'b0;
          busy          <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cordic_req_arbiter.md
Name: cordic_req_arbiter

Overview:
Shares one iterative CORDIC engine between NUM_REQ requesters.
- Latches one float angle per transaction and drives the engine's level-held clk_en.
- Waits for the engine's done, returns the float result to the granted requester, then drops clk_en so the engine returns to its idle state.
- Uses round-robin arbitration. Sits between the trig-consuming datapaths and the single CORDIC instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
REQ_IDX_WIDTH, 2, width of requester index, equals clog2(NUM_REQ)
FLOAT_DATA_WIDTH, 32, IEEE-754 single angle/result width
TIMEOUT_WIDTH, 10, watchdog counter width
TIMEOUT_CYCLES, 1000, cycles allowed from engine start to engine done

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  NUM_REQ  per-requester request, held until accepted
req_angle  in  NUM_REQ*FLOAT_DATA_WIDTH  packed angles; slice i = [i*32 +: 32]
req_ready  out  NUM_REQ  one-hot accept pulse, one cycle
rsp_valid  out  NUM_REQ  one-hot response pulse, one cycle
rsp_result  out  FLOAT_DATA_WIDTH  result, valid while any rsp_valid bit is high
rsp_error  out  1  high with rsp_valid when the transaction timed out
busy  out  1  high whenever state is not IDLE
cordic_clk_en  out  1  engine start/hold level
cordic_angle  out  FLOAT_DATA_WIDTH  registered angle to engine
cordic_done  in  1  engine done level
cordic_result  in  FLOAT_DATA_WIDTH  engine result, valid while cordic_done is high

Behaviour:
- Reset: rst is synchronous and active-high; the clock is clk.
- Reset values: all outputs 0, state IDLE, rr_ptr = 0, watchdog = 0.
- Reset mid-operation: state goes to IDLE and cordic_clk_en drops on the same edge. No response is emitted for the in-flight request.
- States: IDLE, GRANT, RUN, RESP, RELEASE.
- IDLE:
  - If any req_valid is set, select the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Pulse req_ready[g], latch cordic_angle from req_angle slice g, store g, go to GRANT.
- GRANT: assert cordic_clk_en, clear watchdog, go to RUN.
- RUN: hold cordic_clk_en and increment the watchdog each cycle. On cordic_done = 1, capture cordic_result and go to RESP.
- RESP:
  - Pulse rsp_valid[g] with rsp_result for one cycle; rsp_error = 0.
  - Set rr_ptr = (g+1) mod NUM_REQ.
  - Drop cordic_clk_en, go to RELEASE.
- RELEASE: wait for cordic_done = 0, then go to IDLE. This guarantees the engine is back in its idle state before it is re-armed.
- Latency, request accepted to response: 2 cycles + engine latency + 1. The minimum is 4 cycles when the engine asserts done on its first enabled cycle (engine short-cut for 0 and pi/4).
- Simultaneous requests: exactly one grant per transaction. A requester is not re-granted while another valid requester sits between it and rr_ptr.
- req_valid dropping before req_ready is legal; that request is simply never granted.
- A requester whose request is accepted must not present a new request until it has seen its own rsp_valid (no overlap per requester).
- cordic_done seen in IDLE or GRANT is ignored.

Optional Feature:
CORDIC_ARB_TIMEOUT_EN
- Defined: in RUN, if the watchdog reaches TIMEOUT_CYCLES without cordic_done, go to RESP.
  - rsp_result = 0x7FC00000 (quiet NaN), rsp_error = 1.
  - Drop cordic_clk_en, then RELEASE as normal.
  - If done never clears, RELEASE exits after a further TIMEOUT_CYCLES.
- Undefined: the watchdog logic is absent, rsp_error is tied 0, and RUN waits indefinitely.

Test Plan:
1. Single request: req_valid = 0001, angle 0x00000000; engine model done after 1 cycle with 0x3F800000 -> req_ready[0] pulses, rsp_valid[0] pulses with result 0x3F800000, 4 cycles after accept.
2. All four request together and stay asserted; engine latency 12 cycles -> grant order 0,1,2,3,0. Each rsp_valid goes to the matching index with that requester's echoed angle-derived result.
3. Engine holds done for 3 cycles after clk_en drops -> no new grant until done = 0; the next cordic_clk_en rises at least 2 cycles after done falls.
4. rst asserted during RUN with req 2 granted -> next cycle all outputs 0 and rr_ptr = 0. Re-raising req 2 alone gives a fresh grant with exactly one response.
5. With CORDIC_ARB_TIMEOUT_EN, engine never asserts done -> after 1000 cycles rsp_valid[g] = 1, rsp_result = 0x7FC00000, rsp_error = 1, then IDLE.
6. req 1 drops req_valid while req 3 is granted -> req 1 receives no req_ready, and no rsp_valid[1] ever appears.
